soham_kapur_echo_frontend: RTL

Upstream front end for the multi-sensor response checker. It fires a fixed-width trigger burst on a masked set of up to 32 ultrasonic sensors and conditions the raw asynchronous echo lines with a synchronizer and glitch filter. It then records which sensors produced an echo rising edge inside a programmable listen window. `echo_clean` / `echo_seen` feed the checker's `echo` input; `trig_out` drives the sensor pins.

---
 rtl/echo_frontend_pkg.sv | 26 ++
 rtl/echo_frontend_echo_channel_filter.sv | 43 ++++
 rtl/soham_kapur_echo_frontend.sv | 126 ++++++++++++
 3 files changed

// File: rtl/echo_frontend_pkg.sv
// Shared types and helpers for the ultrasonic echo front end.
// Holds the FSM state encoding, default parameters and a lowest-set-bit encoder.
package echo_frontend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRIG   = 2'd1,
    ST_LISTEN = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_N_SENSORS   = 32;
  localparam int DEF_TRIG_CYCLES = 640;
  localparam int DEF_FILT        = 3;
  localparam int DEF_WIN_W       = 32;
  localparam int MAX_SENSORS     = 32;

  // Scanning from the top down leaves the lowest set bit as the final answer.
  function automatic logic [4:0] lsb_index(input logic [MAX_SENSORS-1:0] v);
    lsb_index = '0;
    for (int i = MAX_SENSORS - 1; i >= 0; i--) begin
      if (v[i]) lsb_index = i[4:0];
    end
  endfunction

endpackage

// File: rtl/echo_frontend_echo_channel_filter.sv
// One echo channel: 2-flop synchronizer feeding a FILT-sample hysteresis filter.
// A raw level change reaches o_echo_clean 2+FILT clocks later; never stalls.
module echo_channel_filter
  import echo_frontend_pkg::*;
#(
  parameter int FILT = DEF_FILT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_echo_raw,
  output logic o_echo_clean
);

  logic            r_sync1;
  logic            r_sync2;
  logic [FILT-2:0] r_hist;
  logic            r_clean;
  logic [FILT-1:0] w_win;

  // The newest synchronized sample completes the FILT-wide window, saving one
  // clock versus filtering only on stored history.
  assign w_win = {r_hist, r_sync2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= '0;
      r_clean <= 1'b0;
    end else begin
      r_sync1 <= i_echo_raw;
      r_sync2 <= r_sync1;
      r_hist  <= w_win[FILT-2:0];
      if (&w_win)
        r_clean <= 1'b1;
      else if (~|w_win)
        r_clean <= 1'b0;
    end
  end

  assign o_echo_clean = r_clean;

endmodule

// File: rtl/soham_kapur_echo_frontend.sv
// Ultrasonic front end: masked trigger burst, echo conditioning, windowed rise capture.
// Trigger follows accepted start by one clock; done pulses one clock after the window.
module soham_kapur_echo_frontend
  import echo_frontend_pkg::*;
#(
  parameter int N_SENSORS   = DEF_N_SENSORS,
  parameter int TRIG_CYCLES = DEF_TRIG_CYCLES,
  parameter int FILT        = DEF_FILT,
  parameter int WIN_W       = DEF_WIN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N_SENSORS-1:0] active_mask,
  input  logic [WIN_W-1:0]     window,
  input  logic [N_SENSORS-1:0] echo_raw,
  output logic [N_SENSORS-1:0] trig_out,
  output logic [N_SENSORS-1:0] echo_clean,
  output logic [N_SENSORS-1:0] echo_seen,
  output logic [4:0]           first_idx,
  output logic                 first_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam int CNT_W  = (WIN_W > TRIG_W) ? WIN_W : TRIG_W;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [N_SENSORS-1:0]   r_mask;
  logic [WIN_W-1:0]       r_win_last;
  logic [N_SENSORS-1:0]   r_clean_d;
  logic [N_SENSORS-1:0]   r_seen;
  logic [4:0]             r_first_idx;
  logic                   r_first_valid;
  logic [N_SENSORS-1:0]   w_clean;
  logic [N_SENSORS-1:0]   w_rise;
  logic                   w_trig_term;
  logic                   w_win_term;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_chan
    echo_channel_filter #(.FILT(FILT)) u_filt (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_echo_raw   (echo_raw[g]),
      .o_echo_clean (w_clean[g])
    );
  end

  assign w_rise      = w_clean & ~r_clean_d & r_mask;
  assign w_trig_term = (r_cnt == CNT_W'(TRIG_CYCLES - 1));
  assign w_win_term  = (r_cnt == CNT_W'(r_win_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_clean_d <= '0;
    else
      r_clean_d <= w_clean;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_mask        <= '0;
      r_win_last    <= '0;
      r_seen        <= '0;
      r_first_idx   <= '0;
      r_first_valid <= 1'b0;
    end else if (abort) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_seen        <= '0;
      r_first_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mask        <= active_mask;
            // Storing window-1 lets a zero window collapse to a single cycle.
            r_win_last    <= (window == '0) ? '0 : window - 1'b1;
            r_seen        <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
            r_cnt         <= '0;
            r_state       <= ST_TRIG;
          end
        end
        ST_TRIG: begin
          if (w_trig_term) begin
            r_cnt   <= '0;
            r_state <= ST_LISTEN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_LISTEN: begin
          r_seen <= r_seen | w_rise;
          if (!r_first_valid && (|w_rise)) begin
            r_first_idx   <= lsb_index(MAX_SENSORS'(w_rise));
            r_first_valid <= 1'b1;
          end
          if (w_win_term) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign trig_out    = (r_state == ST_TRIG) ? r_mask : '0;
  assign echo_clean  = w_clean;
  assign echo_seen   = r_seen;
  assign first_idx   = r_first_idx;
  assign first_valid = r_first_valid;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);

endmodule
